// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared-bus generator/arbiter: pops one packet from a pending device FIFO and pushes it to its
// destination device(s). Define BUS_RR_ARB_EN for round-robin arbitration (fixed priority otherwise).
module bs_gnrtr_n_rbtr #(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = {8{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [drvrs-1:0]   pndng  [bits],
  input  logic [pckg_sz-1:0] D_pop  [bits][drvrs],
  output logic [drvrs-1:0]   pop    [bits],
  output logic [drvrs-1:0]   push   [bits],
  output logic [pckg_sz-1:0] D_push [bits][drvrs]
);

  localparam int GW = $clog2(drvrs);

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t             r_state, w_state_nx;
    logic [drvrs-1:0]   r_pop, w_pop_nx;
    logic [drvrs-1:0]   r_push, w_push_nx;
    logic [pckg_sz-1:0] r_pkt, w_pkt_nx;
    logic [pckg_sz-1:0] r_d_push, w_d_push_nx;
    logic [GW-1:0]      r_src, w_src_nx;
    logic [GW-1:0]      w_grant;
    logic               w_any;
    logic [7:0]         w_id;

`ifdef BUS_RR_ARB_EN
    logic [GW-1:0] r_last_grant, w_last_grant_nx;
    logic [GW-1:0] w_idx;

    // Descending offset scan so the nearest pending device after last_grant is the final winner.
    always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      w_idx   = '0;
      for (int i = drvrs; i >= 1; i--) begin
        w_idx = GW'((int'(r_last_grant) + i) % drvrs);
        if (pndng[b][w_idx]) begin
          w_grant = w_idx;
          w_any   = 1'b1;
        end
      end
    end
`else
    always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      for (int i = drvrs - 1; i >= 0; i--) begin
        if (pndng[b][i]) begin
          w_grant = GW'(i);
          w_any   = 1'b1;
        end
      end
    end
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
      w_state_nx  = r_state;
      w_pop_nx    = '0;
      w_push_nx   = '0;
      w_pkt_nx    = r_pkt;
      w_src_nx    = r_src;
      w_d_push_nx = r_d_push;
`ifdef BUS_RR_ARB_EN
      w_last_grant_nx = r_last_grant;
`endif
      w_id = r_pkt[pckg_sz-1 -: 8];
      case (r_state)
        IDLE: begin
          if (w_any) begin
            w_pop_nx[w_grant] = 1'b1;
            w_pkt_nx          = D_pop[b][w_grant];
            w_src_nx          = w_grant;
`ifdef BUS_RR_ARB_EN
            w_last_grant_nx   = w_grant;
`endif
            w_state_nx        = POP;
          end
        end
        POP: begin
          w_d_push_nx = r_pkt;
          // IDs that are neither broadcast nor a valid device leave push all-zero (dropped).
          for (int d = 0; d < drvrs; d++) begin
            if (w_id == broadcast) w_push_nx[d] = (GW'(d) != r_src);
            else                   w_push_nx[d] = (w_id == 8'(d));
          end
          w_state_nx = PUSH;
        end
        PUSH:    w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state  <= IDLE;
        r_pop    <= '0;
        r_push   <= '0;
        r_pkt    <= '0;
        r_src    <= '0;
        r_d_push <= '0;
`ifdef BUS_RR_ARB_EN
        r_last_grant <= GW'(drvrs - 1);
`endif
      end else begin
        r_state  <= w_state_nx;
        r_pop    <= w_pop_nx;
        r_push   <= w_push_nx;
        r_pkt    <= w_pkt_nx;
        r_src    <= w_src_nx;
        r_d_push <= w_d_push_nx;
`ifdef BUS_RR_ARB_EN
        r_last_grant <= w_last_grant_nx;
`endif
      end
    end

    assign pop[b]  = r_pop;
    assign push[b] = r_push;
    for (genvar d = 0; d < drvrs; d++) begin : g_lane
      assign D_push[b][d] = r_d_push;
    end
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Self-checking bench for bs_gnrtr_n_rbtr (drvrs=4, pckg_sz=16, bits=1): directed cases plus
// randomized traffic against a transaction-level model of per-device FIFOs.
module tb_bs_gnrtr_n_rbtr;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng  [1];
  logic [15:0] D_pop  [1][N];
  logic [3:0]  pop    [1];
  logic [3:0]  push   [1];
  logic [15:0] D_push [1][N];

  int checks   = 0;
  int failures = 0;

  logic [15:0] q [N][$];
  int          last_grant;

  bs_gnrtr_n_rbtr #(.bits(1), .drvrs(N), .pckg_sz(16)) dut (
    .clk   (clk),
    .reset (reset),
    .pndng (pndng),
    .D_pop (D_pop),
    .pop   (pop),
    .push  (push),
    .D_push(D_push)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lanes();
    return {D_push[0][3], D_push[0][2], D_push[0][1], D_push[0][0]};
  endfunction

  // Arbitration rule applied to a pending vector.
  function automatic int exp_grant(input logic [3:0] p);
`ifdef BUS_RR_ARB_EN
    for (int i = 1; i <= N; i++)
      if (p[(last_grant + i) % N]) return (last_grant + i) % N;
`else
    for (int i = 0; i < N; i++)
      if (p[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [15:0] pkt, input int src);
    int id;
    id = int'(pkt[15:8]);
    if (id == 255) return 4'hF & ~(4'b1 << src);
    if (id < N)    return 4'b1 << id;
    return 4'h0;
  endfunction

  function automatic logic [15:0] rand_pkt();
    logic [7:0] id;
    case ($urandom_range(0, 3))
      0, 1:    id = 8'($urandom_range(0, 3));
      2:       id = 8'hFF;
      default: id = 8'($urandom_range(4, 254));
    endcase
    return {id, 8'($urandom)};
  endfunction

  task automatic drive_inputs();
    for (int d = 0; d < N; d++) begin
      pndng[0][d] = (q[d].size() != 0);
      D_pop[0][d] = (q[d].size() != 0) ? q[d][0] : 16'hDEAD;
    end
  endtask

  // One complete pop/push transfer; the DUT is in IDLE when this is called.
  task automatic do_xfer(input string tag);
    int          g;
    logic [15:0] pkt;
    drive_inputs();
    g = exp_grant(pndng[0]);
    if (g < 0) begin
      tick();
      check({tag, " idle pop"},  64'(pop[0]),  64'h0);
      check({tag, " idle push"}, 64'(push[0]), 64'h0);
      return;
    end
    pkt = q[g][0];
    tick();
    check($sformatf("%s pop g=%0d", tag, g), 64'(pop[0]), 64'(4'b1 << g));
    check({tag, " push during pop"}, 64'(push[0]), 64'h0);
    void'(q[g].pop_front());
    last_grant = g;
    drive_inputs();
    tick();
    check({tag, " pop cleared"}, 64'(pop[0]), 64'h0);
    check({tag, " push mask"}, 64'(push[0]), 64'(exp_mask(pkt, g)));
    check({tag, " D_push"}, lanes(), {4{pkt}});
    tick();
    check({tag, " push cleared"}, 64'(push[0]), 64'h0);
    check({tag, " pop idle"}, 64'(pop[0]), 64'h0);
    check({tag, " D_push hold"}, lanes(), {4{pkt}});
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      drive_inputs();
      tick();
      check($sformatf("rst pop c%0d", i),  64'(pop[0]),  64'h0);
      check($sformatf("rst push c%0d", i), 64'(push[0]), 64'h0);
      check($sformatf("rst dpush c%0d", i), lanes(), 64'h0);
    end
    reset = 1'b0;
    last_grant = N - 1;
  endtask

  initial begin
    reset = 1'b1;
    last_grant = N - 1;

    // 1: reset held with every device pending.
    for (int d = 0; d < N; d++) q[d].push_back(16'h0100 + 16'(d));
    do_reset(5);
    for (int d = 0; d < N; d++) q[d].delete();
    do_xfer("post-reset empty");

    // 2..4: single unicast, broadcast and invalid-ID transfers.
    q[1].push_back(16'h0234);
    do_xfer("unicast");
    q[0].push_back(16'hFF5A);
    do_xfer("broadcast");
    q[2].push_back(16'h07AA);
    do_xfer("invalid id");

    // 5: all devices pending with one packet each, then a 1010 pattern held for several transfers.
    do_reset(1);
    for (int d = 0; d < N; d++) q[d].push_back({8'(3 - d), 8'h10 + 8'(d)});
    for (int i = 0; i < N; i++) do_xfer($sformatf("all pend %0d", i));
    for (int i = 0; i < 3; i++) q[1].push_back({8'h03, 8'h20 + 8'(i)});
    q[3].push_back(16'h0130);
    for (int i = 0; i < 4; i++) do_xfer($sformatf("1010 %0d", i));

    // 6: reset asserted in the POP cycle aborts the transfer.
    q[2].push_back(16'h01C3);
    drive_inputs();
    tick();
    check("abort pop", 64'(pop[0]), 64'h4);
    void'(q[2].pop_front());
    do_reset(2);
    q[0].push_back(16'h02E0);
    q[2].push_back(16'h00E2);
    do_xfer("after abort a");
    do_xfer("after abort b");

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--)
        q[$urandom_range(0, N - 1)].push_back(rand_pkt());
      do_xfer($sformatf("rand %0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
